// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
// Imported by the fetch FIFO, its interface and the fetch_unit top.
package fetch_pkg;

    localparam int XLEN_DEFAULT = 32;

    localparam logic [XLEN_DEFAULT-1:0] NOP_INST = 32'h0000_0000;

    typedef struct packed {
        logic [XLEN_DEFAULT-1:0] pc;
        logic [XLEN_DEFAULT-1:0] inst;
    } fetch_entry_t;

    function automatic int cnt_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/fetch_if.sv
// Push/pop bundle between a FIFO owner (master) and the FIFO itself (slave).
// Count is wide enough to hold DEPTH without wrapping.
interface fetch_if
    import fetch_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
);

    localparam int CW = cnt_width(DEPTH);

    logic             push;
    logic [WIDTH-1:0] push_data;
    logic             pop;
    logic             clear;
    logic [WIDTH-1:0] head;
    logic [CW-1:0]    count;
    logic             full;
    logic             empty;

    modport master (
        output push,
        output push_data,
        output pop,
        output clear,
        input  head,
        input  count,
        input  full,
        input  empty
    );

    modport slave (
        input  push,
        input  push_data,
        input  pop,
        input  clear,
        output head,
        output count,
        output full,
        output empty
    );

endinterface

// File: rtl/fetch_fifo.sv
// Synchronous FIFO with clear; head is the oldest entry, valid when not empty.
// Push while full is accepted only when a pop frees a slot in the same cycle.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
) (
    input  logic   clk,
    input  logic   rst,
    fetch_if.slave q
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = cnt_width(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic             full;
    logic             empty;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = q.pop & ~empty;
    assign do_push = q.push & (~full | do_pop);

    always_ff @(posedge clk) begin
        if (rst || q.clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !q.clear) begin
            mem[wr_ptr] <= q.push_data;
        end
    end

    assign q.head  = mem[rd_ptr];
    assign q.count = count;
    assign q.full  = full;
    assign q.empty = empty;

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: credit-limited in-order imem requests, tag FIFO
// of in-flight PCs, and an instruction queue feeding decode.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int XLEN  = XLEN_DEFAULT,
    parameter int DEPTH = 2
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic [XLEN-1:0] pc_i,
    input  logic            pc_valid_i,
    output logic            pc_ready_o,
    input  logic            flush_i,
    output logic            imem_req_o,
    output logic [XLEN-1:0] imem_addr_o,
    input  logic            imem_gnt_i,
    input  logic            imem_rvalid_i,
    input  logic [XLEN-1:0] imem_rdata_i,
    output logic            inst_valid_o,
    output logic [XLEN-1:0] inst_o,
    output logic [XLEN-1:0] inst_pc_o,
    input  logic            inst_ready_i
);

    localparam int CW = cnt_width(DEPTH);
    localparam int EW = $bits(fetch_entry_t);

    fetch_if #(.WIDTH(XLEN), .DEPTH(DEPTH)) tag_q ();
    fetch_if #(.WIDTH(EW),   .DEPTH(DEPTH)) inst_q ();

    logic [CW-1:0] outstanding;
    logic [CW-1:0] outstanding_nxt;
    logic [CW-1:0] discard;
    logic [CW:0]   occ;
    logic          issue;
    logic          resp;
    logic          drop;
    logic          keep;
    fetch_entry_t  head_e;
    fetch_entry_t  hold_e;
    fetch_entry_t  out_e;

    // Queued plus in-flight fetches; discarded ones still hold credit until they return.
    assign occ = {1'b0, inst_q.count} + {1'b0, outstanding};

    assign imem_req_o  = pc_valid_i & ~flush_i & ~rst_i
                       & (occ < (CW+1)'(DEPTH));
    assign imem_addr_o = {pc_i[XLEN-1:2], 2'b00};
    assign issue       = imem_req_o & imem_gnt_i;
    assign pc_ready_o  = issue;

    assign resp = imem_rvalid_i & ~rst_i & (outstanding != '0);
    assign drop = (discard != '0);
    assign keep = resp & ~drop & ~flush_i;

    assign outstanding_nxt = outstanding + CW'(issue) - CW'(resp);

    assign tag_q.push      = issue;
    assign tag_q.push_data = pc_i;
    assign tag_q.pop       = resp & ~drop;
    assign tag_q.clear     = flush_i;

    assign inst_q.push      = keep;
    assign inst_q.push_data = {tag_q.head, imem_rdata_i};
    assign inst_q.pop       = inst_valid_o & inst_ready_i;
    assign inst_q.clear     = flush_i;

    fetch_fifo #(.WIDTH(XLEN), .DEPTH(DEPTH)) u_tag (
        .clk (clk_i),
        .rst (rst_i),
        .q   (tag_q)
    );

    fetch_fifo #(.WIDTH(EW), .DEPTH(DEPTH)) u_inst (
        .clk (clk_i),
        .rst (rst_i),
        .q   (inst_q)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            outstanding <= '0;
            discard     <= '0;
        end else begin
            outstanding <= outstanding_nxt;
            if (flush_i) begin
                discard <= outstanding_nxt;
            end else if (resp && drop) begin
                discard <= discard - CW'(1);
            end
        end
    end

    // Last presented entry, shown while the queue is empty.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            hold_e <= '{pc: '0, inst: NOP_INST};
        end else if (!inst_q.empty) begin
            hold_e <= head_e;
        end
    end

    assign head_e       = inst_q.head;
    assign out_e        = inst_q.empty ? hold_e : head_e;
    assign inst_valid_o = ~inst_q.empty;
    assign inst_o       = out_e.inst;
    assign inst_pc_o    = out_e.pc;

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            assert (!(imem_rvalid_i && outstanding == '0));
            assert (!(keep && inst_q.full && !inst_q.pop));
            assert (!(issue && tag_q.full));
            assert (!(resp && !drop && tag_q.empty));
            assert (tag_q.count == outstanding - discard);
        end
    end

endmodule
